// File: rtl/crc32_pkg.sv
// CRC32 helpers shared by the receive checker, the generator and the bench.
// Reflected polynomial, one byte per step, word bytes taken MSB first.
package crc32_pkg;

    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;

    typedef enum logic {
        IDLE,
        FRAME
    } crc_state_e;

    function automatic logic [31:0] crc32_byte_f(
        input logic [31:0] crc,
        input logic [7:0]  b
    );
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] crc32_word_f(
        input logic [31:0] crc,
        input logic [31:0] d
    );
        logic [31:0] c;
        c = crc32_byte_f(crc, d[31:24]);
        c = crc32_byte_f(c, d[23:16]);
        c = crc32_byte_f(c, d[15:8]);
        c = crc32_byte_f(c, d[7:0]);
        return c;
    endfunction

endpackage

// File: rtl/crc32_rx_check_if.sv
// Word stream into the CRC32 checker and its verdict/counter outputs.
// master drives the word stream, slave is the checker.
interface crc32_rx_check_if #(
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 16
);
    localparam int WC_W = $clog2(MAX_WORDS) + 1;

    logic            in_valid;
    logic            in_sop;
    logic            in_eop;
    logic [31:0]     in_data;
    logic            out_done;
    logic            out_ok;
    logic [31:0]     out_crc;
    logic [WC_W-1:0] out_words;
    logic            err_abort;
    logic            err_len;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_sop, in_eop, in_data,
        input  out_done, out_ok, out_crc, out_words,
        input  err_abort, err_len, frame_cnt, err_cnt
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_data,
        output out_done, out_ok, out_crc, out_words,
        output err_abort, err_len, frame_cnt, err_cnt
    );

endinterface

// File: rtl/crc32_word_step.sv
// One 32-bit CRC32 step: four chained byte updates, MSB byte first.
module crc32_word_step
    import crc32_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [31:0] data_i,
    output logic [31:0] crc_o
);

    assign crc_o = crc32_word_f(crc_i, data_i);

endmodule

// File: rtl/crc32_rx_check.sv
// Receive-side CRC32 checker: accumulates payload CRC, compares the FCS
// word, registers a per-frame verdict and keeps saturating counters.
module crc32_rx_check
    import crc32_pkg::*;
#(
    parameter int MAX_WORDS  = 256,
    parameter bit FCS_INVERT = 1'b0,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst_n,
    crc32_rx_check_if.slave bus
);

    localparam int WC_W = $clog2(MAX_WORDS) + 1;
    localparam logic [WC_W-1:0] WMAX = WC_W'(MAX_WORDS);
    localparam logic [WC_W-1:0] WONE = WC_W'(1);

    crc_state_e       state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [WC_W-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic [31:0]      ocrc_q, ocrc_d;
    logic [WC_W-1:0]  owords_q, owords_d;
    logic             abort_q, abort_d;
    logic             len_q, len_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    logic [31:0]      step_in;
    logic [31:0]      step_out;
    logic [31:0]      exp_fcs;
    logic             ovl;
    logic [1:0]       err_inc;
    logic [CNT_W:0]   err_sum;

    // A sop word always restarts the accumulator, even mid-frame.
    assign step_in = bus.in_sop ? CRC32_INIT : crc_q;

    crc32_word_step u_step (
        .crc_i  (step_in),
        .data_i (bus.in_data),
        .crc_o  (step_out)
    );

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        ok_d     = ok_q;
        ocrc_d   = ocrc_q;
        owords_d = owords_q;
        abort_d  = 1'b0;
        len_d    = 1'b0;
        exp_fcs  = '0;
        ovl      = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_sop) begin
                abort_d = (state_q == FRAME);
                if (bus.in_eop) begin
                    exp_fcs  = FCS_INVERT ? ~CRC32_INIT : CRC32_INIT;
                    done_d   = 1'b1;
                    ok_d     = (bus.in_data == exp_fcs);
                    ocrc_d   = CRC32_INIT;
                    owords_d = '0;
                    state_d  = IDLE;
                    crc_d    = CRC32_INIT;
                    cnt_d    = '0;
                end else begin
                    state_d = FRAME;
                    crc_d   = step_out;
                    cnt_d   = WONE;
                end
            end else if (state_q == FRAME) begin
                if (bus.in_eop) begin
                    exp_fcs  = FCS_INVERT ? ~crc_q : crc_q;
                    ovl      = (cnt_q >= WMAX);
                    done_d   = 1'b1;
                    ok_d     = (bus.in_data == exp_fcs) && !ovl;
                    ocrc_d   = crc_q;
                    owords_d = cnt_q;
                    len_d    = ovl;
                    state_d  = IDLE;
                    crc_d    = CRC32_INIT;
                    cnt_d    = '0;
                end else begin
                    crc_d = step_out;
                    if (cnt_q != WMAX) cnt_d = cnt_q + WONE;
                end
            end
        end
    end

    // Abort and failed verdict can coincide on a mid-frame sop&eop word.
    always_comb begin
        fcnt_d = fcnt_q;
        if (done_d && (fcnt_q != '1)) fcnt_d = fcnt_q + 1'b1;
        err_inc = {1'b0, done_d & ~ok_d} + {1'b0, abort_d};
        err_sum = {1'b0, ecnt_q} + (CNT_W + 1)'(err_inc);
        ecnt_d  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            crc_q    <= CRC32_INIT;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            ocrc_q   <= '0;
            owords_q <= '0;
            abort_q  <= 1'b0;
            len_q    <= 1'b0;
            fcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            ocrc_q   <= ocrc_d;
            owords_q <= owords_d;
            abort_q  <= abort_d;
            len_q    <= len_d;
            fcnt_q   <= fcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign bus.out_done  = done_q;
    assign bus.out_ok    = ok_q;
    assign bus.out_crc   = ocrc_q;
    assign bus.out_words = owords_q;
    assign bus.err_abort = abort_q;
    assign bus.err_len   = len_q;
    assign bus.frame_cnt = fcnt_q;
    assign bus.err_cnt   = ecnt_q;

endmodule

// File: tb/tb_crc32_rx_check.sv
// Directed bench for crc32_rx_check: a default instance and a small one
// (MAX_WORDS=4, CNT_W=4) share one word stream.
module tb_crc32_rx_check;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, sop, eop;
    logic [31:0] data;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    crc32_rx_check_if #(.MAX_WORDS(256), .CNT_W(16)) bus_a ();
    crc32_rx_check_if #(.MAX_WORDS(4), .CNT_W(4)) bus_b ();

    assign bus_a.in_valid = valid;
    assign bus_a.in_sop   = sop;
    assign bus_a.in_eop   = eop;
    assign bus_a.in_data  = data;
    assign bus_b.in_valid = valid;
    assign bus_b.in_sop   = sop;
    assign bus_b.in_eop   = eop;
    assign bus_b.in_data  = data;

    crc32_rx_check #(.MAX_WORDS(256), .FCS_INVERT(1'b0), .CNT_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    crc32_rx_check #(.MAX_WORDS(4), .FCS_INVERT(1'b0), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Bit-serial reflected CRC32, bytes MSB first, each byte LSB first.
    function automatic logic [31:0] model_word(
        input logic [31:0] c_in,
        input logic [31:0] d
    );
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int k = 3; k >= 0; k--) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ d[8*k+i];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return c;
    endfunction

    task automatic drive(input logic s, input logic e, input logic [31:0] d);
        valid = 1'b1;
        sop   = s;
        eop   = e;
        data  = d;
        @(negedge clk);
    endtask

    task automatic idle_in();
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({bus_a.out_done, bus_a.out_ok, bus_a.out_crc, bus_a.out_words,
             bus_a.err_abort, bus_a.err_len, bus_a.frame_cnt,
             bus_a.err_cnt} !== '0)
            $display("FAIL reset_a: got done=%b ok=%b crc=%h fc=%0d ec=%0d want all 0",
                     bus_a.out_done, bus_a.out_ok, bus_a.out_crc,
                     bus_a.frame_cnt, bus_a.err_cnt);
        else n_pass++;
        n_total++;
        if ({bus_b.out_done, bus_b.out_ok, bus_b.out_crc, bus_b.out_words,
             bus_b.err_abort, bus_b.err_len, bus_b.frame_cnt,
             bus_b.err_cnt} !== '0)
            $display("FAIL reset_b: got done=%b ok=%b crc=%h want all 0",
                     bus_b.out_done, bus_b.out_ok, bus_b.out_crc);
        else n_pass++;
    endtask

    task automatic test_good_frame();
        logic [31:0] fcs;
        do_reset();
        fcs = model_word(model_word(32'hFFFFFFFF, 32'h0), 32'h12345678);
        drive(1'b1, 1'b0, 32'h00000000);
        drive(1'b0, 1'b0, 32'h12345678);
        drive(1'b0, 1'b1, fcs);
        idle_in();
        n_total++;
        if (bus_a.out_done !== 1'b1 || bus_a.out_ok !== 1'b1)
            $display("FAIL good_verdict: got done=%b ok=%b want 1 1",
                     bus_a.out_done, bus_a.out_ok);
        else n_pass++;
        n_total++;
        if (bus_a.out_words !== 9'd2 || bus_a.out_crc !== fcs)
            $display("FAIL good_words_crc: got %0d %h want 2 %h",
                     bus_a.out_words, bus_a.out_crc, fcs);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus_a.out_done !== 1'b0 || bus_a.out_ok !== 1'b1 ||
            bus_a.frame_cnt !== 16'd1)
            $display("FAIL good_hold: got done=%b ok=%b fc=%0d want 0 1 1",
                     bus_a.out_done, bus_a.out_ok, bus_a.frame_cnt);
        else n_pass++;
    endtask

    task automatic test_bad_fcs();
        logic [31:0] fcs;
        do_reset();
        fcs = model_word(model_word(32'hFFFFFFFF, 32'h0), 32'h12345678);
        drive(1'b1, 1'b0, 32'h00000000);
        drive(1'b0, 1'b0, 32'h12345678);
        drive(1'b0, 1'b1, fcs ^ 32'h1);
        idle_in();
        n_total++;
        if (bus_a.out_done !== 1'b1 || bus_a.out_ok !== 1'b0 ||
            bus_a.out_crc !== fcs)
            $display("FAIL bad_verdict: got done=%b ok=%b crc=%h want 1 0 %h",
                     bus_a.out_done, bus_a.out_ok, bus_a.out_crc, fcs);
        else n_pass++;
        n_total++;
        if (bus_a.err_cnt !== 16'd1 || bus_a.frame_cnt !== 16'd1)
            $display("FAIL bad_counts: got ec=%0d fc=%0d want 1 1",
                     bus_a.err_cnt, bus_a.frame_cnt);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] fcs;
        do_reset();
        fcs = model_word(model_word(32'hFFFFFFFF, 32'h11111111), 32'h22222222);
        drive(1'b1, 1'b0, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 32'h11111111);
        n_total++;
        if (bus_a.err_abort !== 1'b1 || bus_a.out_done !== 1'b0)
            $display("FAIL abort_pulse: got abort=%b done=%b want 1 0",
                     bus_a.err_abort, bus_a.out_done);
        else n_pass++;
        drive(1'b0, 1'b0, 32'h22222222);
        n_total++;
        if (bus_a.err_abort !== 1'b0)
            $display("FAIL abort_clear: got %b want 0", bus_a.err_abort);
        else n_pass++;
        drive(1'b0, 1'b1, fcs);
        idle_in();
        n_total++;
        if (bus_a.out_done !== 1'b1 || bus_a.out_ok !== 1'b1 ||
            bus_a.out_words !== 9'd2)
            $display("FAIL abort_frame_b: got done=%b ok=%b words=%0d want 1 1 2",
                     bus_a.out_done, bus_a.out_ok, bus_a.out_words);
        else n_pass++;
        n_total++;
        if (bus_a.err_cnt !== 16'd1 || bus_a.frame_cnt !== 16'd1)
            $display("FAIL abort_counts: got ec=%0d fc=%0d want 1 1",
                     bus_a.err_cnt, bus_a.frame_cnt);
        else n_pass++;
    endtask

    task automatic test_zero_payload();
        do_reset();
        drive(1'b0, 1'b1, 32'hFFFFFFFF);
        idle_in();
        @(negedge clk);
        n_total++;
        if (bus_a.out_done !== 1'b0 || bus_a.frame_cnt !== 16'd0)
            $display("FAIL drop_idle: got done=%b fc=%0d want 0 0",
                     bus_a.out_done, bus_a.frame_cnt);
        else n_pass++;
        drive(1'b1, 1'b1, 32'hFFFFFFFF);
        idle_in();
        n_total++;
        if (bus_a.out_done !== 1'b1 || bus_a.out_ok !== 1'b1 ||
            bus_a.out_words !== 9'd0 || bus_a.out_crc !== 32'hFFFFFFFF)
            $display("FAIL zero_ok: got done=%b ok=%b words=%0d crc=%h want 1 1 0 ffffffff",
                     bus_a.out_done, bus_a.out_ok, bus_a.out_words, bus_a.out_crc);
        else n_pass++;
        drive(1'b1, 1'b1, 32'h00000000);
        idle_in();
        n_total++;
        if (bus_a.out_done !== 1'b1 || bus_a.out_ok !== 1'b0 ||
            bus_a.err_cnt !== 16'd1)
            $display("FAIL zero_bad: got done=%b ok=%b ec=%0d want 1 0 1",
                     bus_a.out_done, bus_a.out_ok, bus_a.err_cnt);
        else n_pass++;
        // CRC32 of four zero bytes is 2144DF1C; raw register is its inverse.
        drive(1'b1, 1'b0, 32'h00000000);
        drive(1'b0, 1'b1, 32'hDEBB20E3);
        idle_in();
        n_total++;
        if (bus_a.out_ok !== 1'b1 || bus_a.out_crc !== 32'hDEBB20E3 ||
            bus_a.frame_cnt !== 16'd3)
            $display("FAIL known_crc: got ok=%b crc=%h fc=%0d want 1 debb20e3 3",
                     bus_a.out_ok, bus_a.out_crc, bus_a.frame_cnt);
        else n_pass++;
    endtask

    task automatic test_overlength();
        logic [31:0] c;
        logic [31:0] d;
        do_reset();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            d = 32'hA5000000 + 32'(i * 32'h01010101);
            c = model_word(c, d);
            drive(i == 0, 1'b0, d);
        end
        drive(1'b0, 1'b1, c);
        idle_in();
        n_total++;
        if (bus_b.out_done !== 1'b1 || bus_b.out_ok !== 1'b0 ||
            bus_b.err_len !== 1'b1 || bus_b.out_words !== 3'd4)
            $display("FAIL overlen: got done=%b ok=%b len=%b words=%0d want 1 0 1 4",
                     bus_b.out_done, bus_b.out_ok, bus_b.err_len, bus_b.out_words);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus_b.err_len !== 1'b0)
            $display("FAIL overlen_clear: got %b want 0", bus_b.err_len);
        else n_pass++;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            d = 32'h3C000001 + 32'(i * 32'h00770007);
            c = model_word(c, d);
            drive(i == 0, 1'b0, d);
        end
        drive(1'b0, 1'b1, c);
        idle_in();
        n_total++;
        if (bus_b.out_ok !== 1'b1 || bus_b.err_len !== 1'b0 ||
            bus_b.out_words !== 3'd3 || bus_b.err_cnt !== 4'd1)
            $display("FAIL exact_max: got ok=%b len=%b words=%0d ec=%0d want 1 0 3 1",
                     bus_b.out_ok, bus_b.err_len, bus_b.out_words, bus_b.err_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] e;
        logic [31:0] c;
        logic [31:0] d;
        int          n;
        int          pushed;
        int          pushed_after;
        int          seen;
        int          tail;
        int          guard;
        int          fc_exp;
        bit          drv_done;
        pushed = 0;
        pushed_after = 0;
        seen = 0;
        tail = 0;
        guard = 0;
        drv_done = 1'b0;
        do_reset();
        fork
            begin
                for (int f = 0; f < 100; f++) begin
                    n = (f == 20) ? 3 : int'($urandom_range(1, 3));
                    c = 32'hFFFFFFFF;
                    for (int w = 0; w <= n; w++) begin
                        while ($urandom_range(0, 3) == 0) begin
                            valid = 1'b0;
                            sop   = 1'($urandom_range(0, 1));
                            eop   = 1'($urandom_range(0, 1));
                            data  = $urandom;
                            @(negedge clk);
                        end
                        if (w == n) begin
                            if (f != 20) begin
                                exp_q.push_back(c);
                                pushed++;
                                if (f > 20) pushed_after++;
                            end
                            drive(1'b0, 1'b1, c);
                        end else begin
                            d = $urandom;
                            c = model_word(c, d);
                            drive(w == 0, 1'b0, d);
                        end
                        // Mid-frame reset: remaining words land in IDLE and are dropped.
                        if (f == 20 && w == 1) begin
                            idle_in();
                            rst_n = 1'b0;
                            repeat (2) @(negedge clk);
                            rst_n = 1'b1;
                        end
                    end
                end
                idle_in();
                drv_done = 1'b1;
            end
            begin
                while (tail < 4 && guard < 20000) begin
                    @(negedge clk);
                    guard++;
                    if (drv_done) tail++;
                    if (bus_b.out_done === 1'b1) begin
                        seen++;
                        n_total++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL b2b_spurious: got out_done=1 want no verdict");
                        end else begin
                            e = exp_q.pop_front();
                            if (bus_b.out_ok !== 1'b1 || bus_b.out_crc !== e)
                                $display("FAIL b2b_verdict: got ok=%b crc=%h want 1 %h",
                                         bus_b.out_ok, bus_b.out_crc, e);
                            else n_pass++;
                        end
                    end
                end
            end
        join
        n_total++;
        if (seen != pushed || exp_q.size() != 0 || guard >= 20000)
            $display("FAIL b2b_count: got %0d verdicts (%0d left) want %0d",
                     seen, exp_q.size(), pushed);
        else n_pass++;
        fc_exp = (pushed_after > 15) ? 15 : pushed_after;
        n_total++;
        if (bus_b.frame_cnt !== 4'(fc_exp) || bus_b.err_cnt !== 4'd0)
            $display("FAIL b2b_sat: got fc=%0d ec=%0d want %0d 0",
                     bus_b.frame_cnt, bus_b.err_cnt, fc_exp);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
        data  = '0;
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_abort();
        test_zero_payload();
        test_overlength();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
